// File: rtl/pipe_hazard_ctrl.sv
// Decode-side interlock: tracks in-flight destinations, stalls load-use, selects forwarding sources.
// Latency: stall/issue/fwd are combinational from tracked entries and decode inputs; entries shift every clk.
// Backpressure: stall holds PC/IFID and injects a bubble; flush overrides stall and kills the EX occupant.
module pipe_hazard_ctrl #(
  parameter int STAGES      = 3,
  parameter int REG_AW      = 4,
  parameter int LOAD_LAT    = 1,
  parameter int FLUSH_DEPTH = 1,
  parameter int ZERO_REG    = 1,
  parameter int SEL_W       = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_we,
  input  logic              id_load,
  input  logic              flush,
  output logic              stall,
  output logic              issue,
  output logic [SEL_W-1:0]  fwd_rs,
  output logic [SEL_W-1:0]  fwd_rt,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
);

  // One tracked in-flight instruction: entry 0 shadows IDEX, entry STAGES-1 shadows the WB register.
  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              we;
    logic              ld;
  } ent_t;

  ent_t ent_q [STAGES];
  ent_t ent_d [STAGES];
  logic haz_rs;
  logic haz_rt;

  // A source hits an entry only if that entry really writes the register the source really reads.
  function automatic logic src_match(input ent_t e, input logic [REG_AW-1:0] s, input logic used);
    return e.v & e.we & (e.rd == s) & used & ~((ZERO_REG != 0) & (s == '0));
  endfunction

  // Scan oldest to youngest so the youngest producer overwrites; a hazard is judged only on that producer.
  always_comb begin
    fwd_rs = '0;
    fwd_rt = '0;
    haz_rs = 1'b0;
    haz_rt = 1'b0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (src_match(ent_q[i], id_rs, id_rs_used)) begin
        fwd_rs = SEL_W'(i + 1);
        haz_rs = ent_q[i].ld & (i < LOAD_LAT);
      end
      if (src_match(ent_q[i], id_rt, id_rt_used)) begin
        fwd_rt = SEL_W'(i + 1);
        haz_rt = ent_q[i].ld & (i < LOAD_LAT);
      end
    end
  end

  // Flush wins over stall; either one keeps the decode instruction out of entry 0.
  always_comb begin
    stall = id_valid & (haz_rs | haz_rt) & ~flush;
    issue = id_valid & ~stall & ~flush;
  end

  // Next tracking contents: new instruction (or bubble) enters, everything ages, flush kills the young end.
  always_comb begin
    ent_d[0] = '{v: issue, rd: id_rd, we: id_we, ld: id_load};
    for (int i = 1; i < STAGES; i++) begin
      ent_d[i] = ent_q[i-1];
      if (flush && (i <= FLUSH_DEPTH)) begin
        ent_d[i].v = 1'b0;
      end
    end
  end

  // Tracking register: the downstream pipeline never freezes, so it shifts every cycle.
  always_ff @(posedge clk) begin
    for (int i = 0; i < STAGES; i++) begin
      if (rst) begin
        ent_q[i] <= '0;
      end else begin
        ent_q[i] <= ent_d[i];
      end
    end
  end

  // Saturating event counters for stall and flush cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      if (flush && (flush_cnt != 16'hFFFF)) begin
        flush_cnt <= flush_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic against a queue-based model.
// Two instances share stimulus: default parameters, and a deep variant (16 stages, long load latency).
// Outputs are sampled on the falling edge; inputs change just after the rising edge.
module tb_pipe_hazard_ctrl;

  localparam int A_ST = 3,  A_LL = 1,  A_FD = 1, A_ZR = 1;
  localparam int B_ST = 16, B_LL = 16, B_FD = 2, B_ZR = 0;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_rs_used, id_rt_used, id_we, id_load, flush;
  logic [3:0] id_rs, id_rt, id_rd;

  logic        stall_a, issue_a, stall_b, issue_b;
  logic [1:0]  fwd_rs_a, fwd_rt_a;
  logic [4:0]  fwd_rs_b, fwd_rt_b;
  logic [15:0] stall_cnt_a, flush_cnt_a, stall_cnt_b, flush_cnt_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_we(id_we),
    .id_load(id_load), .flush(flush), .stall(stall_a), .issue(issue_a),
    .fwd_rs(fwd_rs_a), .fwd_rt(fwd_rt_a), .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a)
  );

  pipe_hazard_ctrl #(.STAGES(B_ST), .REG_AW(4), .LOAD_LAT(B_LL), .FLUSH_DEPTH(B_FD), .ZERO_REG(B_ZR)) dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_we(id_we),
    .id_load(id_load), .flush(flush), .stall(stall_b), .issue(issue_b),
    .fwd_rs(fwd_rs_b), .fwd_rt(fwd_rt_b), .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
  );

  // Model: a queue of in-flight instructions, index 0 = youngest (EX).
  typedef struct {
    bit v;
    int rd;
    bit we;
    bit ld;
  } rec_t;
  typedef rec_t rec_q_t[$];

  rec_q_t qa, qb;
  int sca, fca, scb, fcb;

  function automatic int youngest(input rec_q_t q, input int s, input bit used, input int zr);
    if (!used || (zr != 0 && s == 0)) return -1;
    for (int i = 0; i < q.size(); i++)
      if (q[i].v && q[i].we && q[i].rd == s) return i;
    return -1;
  endfunction

  function automatic void model_out(input rec_q_t q, input int ll, input int zr,
                                    output int frs, output int frt, output bit stl, output bit iss);
    int ys, yt;
    bit haz;
    ys  = youngest(q, int'(id_rs), id_rs_used, zr);
    yt  = youngest(q, int'(id_rt), id_rt_used, zr);
    haz = 1'b0;
    if (ys >= 0 && ys < ll && q[ys].ld) haz = 1'b1;
    if (yt >= 0 && yt < ll && q[yt].ld) haz = 1'b1;
    frs = ys + 1;
    frt = yt + 1;
    stl = id_valid && haz && !flush;
    iss = id_valid && !stl && !flush;
  endfunction

  function automatic rec_q_t model_next(input rec_q_t q, input int st, input int fd, input bit iss);
    rec_q_t n;
    rec_t r;
    n = q;
    if (rst) begin
      foreach (n[i]) n[i].v = 1'b0;
      return n;
    end
    r.v = iss; r.rd = int'(id_rd); r.we = id_we; r.ld = id_load;
    n.push_front(r);
    if (flush)
      for (int i = 1; i <= fd && i < n.size(); i++) n[i].v = 1'b0;
    while (n.size() > st) void'(n.pop_back());
    return n;
  endfunction

  function automatic int cnt_next(input int c, input bit inc);
    if (rst) return 0;
    if (inc && c < 65535) return c + 1;
    return c;
  endfunction

  // Called at the falling edge: compare both instances to the model, advance the model, cross the rising edge.
  task automatic adv();
    int frs, frt;
    bit stl, iss;
    model_out(qa, A_LL, A_ZR, frs, frt, stl, iss);
    total++;
    if ({stall_a, issue_a, fwd_rs_a, fwd_rt_a} !== {stl, iss, 2'(frs), 2'(frt)} ||
        stall_cnt_a !== 16'(sca) || flush_cnt_a !== 16'(fca)) begin
      bad++;
      $display("FAIL model_a t=%0t got st=%0b is=%0b frs=%0d frt=%0d sc=%0d fc=%0d want st=%0b is=%0b frs=%0d frt=%0d sc=%0d fc=%0d",
               $time, stall_a, issue_a, fwd_rs_a, fwd_rt_a, stall_cnt_a, flush_cnt_a, stl, iss, frs, frt, sca, fca);
    end
    qa  = model_next(qa, A_ST, A_FD, iss);
    sca = cnt_next(sca, stl);
    fca = cnt_next(fca, flush);

    model_out(qb, B_LL, B_ZR, frs, frt, stl, iss);
    total++;
    if ({stall_b, issue_b, fwd_rs_b, fwd_rt_b} !== {stl, iss, 5'(frs), 5'(frt)} ||
        stall_cnt_b !== 16'(scb) || flush_cnt_b !== 16'(fcb)) begin
      bad++;
      $display("FAIL model_b t=%0t got st=%0b is=%0b frs=%0d frt=%0d sc=%0d fc=%0d want st=%0b is=%0b frs=%0d frt=%0d sc=%0d fc=%0d",
               $time, stall_b, issue_b, fwd_rs_b, fwd_rt_b, stall_cnt_b, flush_cnt_b, stl, iss, frs, frt, scb, fcb);
    end
    qb  = model_next(qb, B_ST, B_FD, iss);
    scb = cnt_next(scb, stl);
    fcb = cnt_next(fcb, flush);

    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int rs, input bit rsu, input int rt, input bit rtu,
                       input int rd, input bit we, input bit ld, input bit fl);
    id_valid = v; id_rs = 4'(rs); id_rs_used = rsu; id_rt = 4'(rt); id_rt_used = rtu;
    id_rd = 4'(rd); id_we = we; id_load = ld; flush = fl;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #4; adv();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    // Reset held with a hazard-looking decode instruction present.
    rst = 1'b1;
    drive(1, 3, 1, 3, 1, 3, 1, 1, 0);
    #4; adv();
    rst = 1'b0;
    #4;
    total++;
    if ({stall_a, fwd_rs_a, fwd_rt_a} !== 5'b0) begin
      bad++; $display("FAIL reset_outputs got st=%0b frs=%0d frt=%0d want 0 0 0", stall_a, fwd_rs_a, fwd_rt_a);
    end
    total++;
    if (stall_cnt_a !== 16'd0 || flush_cnt_a !== 16'd0) begin
      bad++; $display("FAIL reset_counters got sc=%0d fc=%0d want 0 0", stall_cnt_a, flush_cnt_a);
    end
    adv();
    // Reset arriving during a load-use stall.
    do_reset();
    drive(1, 1, 1, 0, 0, 5, 1, 1, 0); #4; adv();
    drive(1, 1, 1, 5, 1, 6, 1, 0, 0); #4;
    total++;
    if (stall_a !== 1'b1) begin
      bad++; $display("FAIL midstall_pre got st=%0b want 1", stall_a);
    end
    rst = 1'b1; adv(); rst = 1'b0; #4;
    total++;
    if (stall_a !== 1'b0 || fwd_rt_a !== 2'd0 || stall_cnt_a !== 16'd0) begin
      bad++; $display("FAIL midstall_post got st=%0b frt=%0d sc=%0d want 0 0 0", stall_a, fwd_rt_a, stall_cnt_a);
    end
    adv();
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1, 1, 1, 2, 1, 3, 1, 0, 0); #4;
    total++;
    if (stall_a !== 1'b0 || issue_a !== 1'b1) begin
      bad++; $display("FAIL b2b_issue got st=%0b is=%0b want 0 1", stall_a, issue_a);
    end
    adv();
    for (int k = 1; k <= 3; k++) begin
      drive(1, 3, 1, 1, 1, 5 + k, 1, 0, 0); #4;
      total++;
      if (stall_a !== 1'b0 || fwd_rs_a !== 2'(k)) begin
        bad++; $display("FAIL b2b_fwd%0d got st=%0b frs=%0d want 0 %0d", k, stall_a, fwd_rs_a, k);
      end
      adv();
    end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1, 1, 1, 0, 0, 5, 1, 1, 0); #4; adv();
    drive(1, 1, 1, 5, 1, 7, 1, 0, 0); #4;
    total++;
    if (stall_a !== 1'b1 || issue_a !== 1'b0 || fwd_rt_a !== 2'd1) begin
      bad++; $display("FAIL lu_stall got st=%0b is=%0b frt=%0d want 1 0 1", stall_a, issue_a, fwd_rt_a);
    end
    adv(); #4;
    total++;
    if (stall_a !== 1'b0 || issue_a !== 1'b1 || fwd_rt_a !== 2'd2 || stall_cnt_a !== 16'd1) begin
      bad++; $display("FAIL lu_release got st=%0b is=%0b frt=%0d sc=%0d want 0 1 2 1", stall_a, issue_a, fwd_rt_a, stall_cnt_a);
    end
    adv();
  endtask

  task automatic test_zero_reg();
    do_reset();
    drive(1, 1, 1, 2, 1, 0, 1, 0, 0); #4; adv();
    drive(1, 0, 1, 0, 0, 4, 1, 0, 0); #4;
    total++;
    if (fwd_rs_a !== 2'd0 || stall_a !== 1'b0) begin
      bad++; $display("FAIL zero_on got frs=%0d st=%0b want 0 0", fwd_rs_a, stall_a);
    end
    total++;
    if (fwd_rs_b !== 5'd1 || stall_b !== 1'b0) begin
      bad++; $display("FAIL zero_off got frs=%0d st=%0b want 1 0", fwd_rs_b, stall_b);
    end
    adv();
  endtask

  task automatic test_flush();
    do_reset();
    drive(1, 1, 1, 0, 0, 2, 1, 1, 0); #4; adv();
    drive(1, 2, 1, 0, 0, 8, 1, 0, 1); #4;
    total++;
    if (stall_a !== 1'b0 || issue_a !== 1'b0) begin
      bad++; $display("FAIL flush_override got st=%0b is=%0b want 0 0", stall_a, issue_a);
    end
    adv();
    drive(1, 2, 1, 8, 1, 9, 1, 0, 0); #4;
    total++;
    if (fwd_rs_a !== 2'd0 || fwd_rt_a !== 2'd0 || stall_a !== 1'b0) begin
      bad++; $display("FAIL flush_killed got frs=%0d frt=%0d st=%0b want 0 0 0", fwd_rs_a, fwd_rt_a, stall_a);
    end
    total++;
    if (flush_cnt_a !== 16'd1 || stall_cnt_a !== 16'd0) begin
      bad++; $display("FAIL flush_counts got fc=%0d sc=%0d want 1 0", flush_cnt_a, stall_cnt_a);
    end
    adv();
  endtask

  task automatic test_youngest();
    do_reset();
    drive(1, 1, 1, 0, 0, 4, 1, 0, 0); #4; adv();
    drive(1, 1, 1, 0, 0, 9, 1, 0, 0); #4; adv();
    drive(1, 1, 1, 0, 0, 4, 1, 0, 0); #4; adv();
    drive(1, 4, 1, 0, 0, 10, 1, 0, 0); #4;
    total++;
    if (fwd_rs_a !== 2'd1 || stall_a !== 1'b0) begin
      bad++; $display("FAIL young_alu got frs=%0d st=%0b want 1 0", fwd_rs_a, stall_a);
    end
    adv();
    do_reset();
    drive(1, 1, 1, 0, 0, 4, 1, 0, 0); #4; adv();
    drive(1, 1, 1, 0, 0, 4, 1, 1, 0); #4; adv();
    drive(1, 0, 0, 4, 1, 11, 1, 0, 0); #4;
    total++;
    if (stall_a !== 1'b1 || fwd_rt_a !== 2'd1) begin
      bad++; $display("FAIL young_load got st=%0b frt=%0d want 1 1", stall_a, fwd_rt_a);
    end
    adv();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
            $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
      #4; adv();
    end
    rst = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset();
    // A load reading its own destination: it re-stalls on itself after every issue.
    drive(1, 5, 1, 0, 0, 5, 1, 1, 0);
    for (int n = 0; n < 70000; n++) begin
      #4; adv();
    end
    #4;
    total++;
    if (stall_cnt_b !== 16'hFFFF) begin
      bad++; $display("FAIL sat_hold got sc=%0h want ffff", stall_cnt_b);
    end
    rst = 1'b1; adv(); rst = 1'b0; #4;
    total++;
    if (stall_cnt_b !== 16'd0 || flush_cnt_b !== 16'd0 || stall_b !== 1'b0 || stall_a !== 1'b0) begin
      bad++; $display("FAIL sat_reset got scb=%0d fcb=%0d stb=%0b sta=%0b want 0 0 0 0",
                      stall_cnt_b, flush_cnt_b, stall_b, stall_a);
    end
    adv();
  endtask

  initial begin
    rec_t z;
    z.v = 1'b0; z.rd = 0; z.we = 1'b0; z.ld = 1'b0;
    for (int i = 0; i < A_ST; i++) qa.push_back(z);
    for (int i = 0; i < B_ST; i++) qb.push_back(z);
    sca = 0; fca = 0; scb = 0; fcb = 0;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    test_reset();
    test_back_to_back();
    test_load_use();
    test_zero_reg();
    test_flush();
    test_youngest();
    test_random();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
